// File: rtl/display_pkg.sv
// Shared definitions for scanned seven-segment display drivers.
package display_pkg;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam int         NUM_DIGITS = 8;

   // Slot phase, exposed for debug and checker binding.
   typedef enum logic [1:0] {
      PH_BLANK = 2'd0,
      PH_ON    = 2'd1,
      PH_OFF   = 2'd2
   } phase_e;

   // Last value of the slot counter: a slot lasts calc_dwell()+1 cycles.
   function automatic int calc_dwell(input int clk_hz, input int digit_hz);
      return (clk_hz / digit_hz) - 1;
   endfunction

   // Terminal count of the blink counter: the blink phase toggles every
   // calc_blink_tc()+1 cycles.
   function automatic int calc_blink_tc(input int clk_hz, input int blink_hz);
      return (clk_hz / (2 * blink_hz)) - 1;
   endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot/digit scan timer: cnt runs 0..DWELL inside a slot, idx steps through
// the digits. Reusable for any time-multiplexed display.
module display_scan_timer
   import display_pkg::*;
#(
   parameter int DWELL     = 9,
   parameter int NUM_SLOTS = NUM_DIGITS,
   parameter int CW        = $clog2(DWELL + 1),
   parameter int IW        = $clog2(NUM_SLOTS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt,
   output logic [IW-1:0] o_idx,
   output logic          o_slot_start,
   output logic          o_frame_start
);

   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_idx;
   logic          w_cnt_last;
   logic          w_idx_last;

   assign w_cnt_last = (r_cnt == CW'(DWELL));
   assign w_idx_last = (r_idx == IW'(NUM_SLOTS - 1));

   // Advance the slot counter every enabled cycle, step the digit at slot end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (!i_en) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_cnt_last) begin
         r_cnt <= '0;
         r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt         = r_cnt;
   assign o_idx         = r_idx;
   assign o_slot_start  = i_en && (r_cnt == '0);
   assign o_frame_start = o_slot_start && (r_idx == '0);

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment panel:
// anti-ghost blank at the start of each slot, 8-level brightness PWM and
// per-digit blinking. All outputs are registered and lag (cnt, idx) by one
// cycle; BLANK_CYC must satisfy 2 <= BLANK_CYC < DWELL+1 so the segment
// update always lands while the anodes are still off.
module display_scan
   import display_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int DIGIT_HZ  = 1000,
   parameter int BLANK_CYC = 16,
   parameter int BLINK_HZ  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [6:0] led1,
   input  logic [6:0] led2,
   input  logic [6:0] led3,
   input  logic [6:0] led4,
   input  logic [6:0] led5,
   input  logic [6:0] led6,
   input  logic [6:0] led7,
   input  logic [6:0] led8,
   input  logic [7:0] blink_mask,
   input  logic [2:0] bright,
   output logic [6:0] seg_n,
   output logic [7:0] an_n,
   output logic       frame_start
);

   localparam int DWELL    = calc_dwell(CLK_HZ, DIGIT_HZ);
   localparam int BLINK_TC = calc_blink_tc(CLK_HZ, BLINK_HZ);
   localparam int CW       = $clog2(DWELL + 1);
   localparam int IW       = $clog2(NUM_DIGITS);
   localparam int BW       = (BLINK_TC > 0) ? $clog2(BLINK_TC + 1) : 1;
   // Cycles available for light after the blank interval.
   localparam int WIN      = DWELL + 1 - BLANK_CYC;

   logic [CW-1:0] w_cnt;
   logic [IW-1:0] w_idx;
   logic          w_slot_start;
   logic          w_frame_start;

   logic [6:0]    w_led [NUM_DIGITS];
   logic [6:0]    w_dig_next;
   logic [31:0]   w_cnt32;
   logic [31:0]   w_on_len;
   phase_e        w_phase;
   logic [7:0]    w_an_on;
   logic          w_blank_blink;

   logic [6:0]    r_dig_q;
   logic [2:0]    r_bright;
   logic [BW-1:0] r_bc;
   logic          r_bp;
   logic [6:0]    r_seg_n;
   logic [7:0]    r_an_n;
   logic          r_frame_start;

   display_scan_timer #(
      .DWELL     (DWELL),
      .NUM_SLOTS (NUM_DIGITS),
      .CW        (CW),
      .IW        (IW)
   ) u_timer (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_en          (en),
      .o_cnt         (w_cnt),
      .o_idx         (w_idx),
      .o_slot_start  (w_slot_start),
      .o_frame_start (w_frame_start)
   );

   assign w_led[0] = led1;
   assign w_led[1] = led2;
   assign w_led[2] = led3;
   assign w_led[3] = led4;
   assign w_led[4] = led5;
   assign w_led[5] = led6;
   assign w_led[6] = led7;
   assign w_led[7] = led8;

   // At slot start the fresh pattern goes straight to the segment register,
   // so the digit and its anode change together one cycle later.
   assign w_dig_next    = w_slot_start ? w_led[w_idx] : r_dig_q;
   assign w_an_on       = ~(8'h01 << w_idx);
   assign w_blank_blink = r_bp && blink_mask[w_idx];

   // Phase decode: BLANK, then on_len cycles of light, then dark remainder.
   // r_bright is only stale at cnt==0, which is always inside BLANK.
   always_comb begin
      w_cnt32  = 32'(w_cnt);
      w_on_len = (32'(WIN) * (32'(r_bright) + 32'd1)) >> 3;
      w_phase  = PH_OFF;
      if (w_cnt32 < 32'(BLANK_CYC)) begin
         w_phase = PH_BLANK;
      end else if (w_cnt32 < (32'(BLANK_CYC) + w_on_len)) begin
         w_phase = PH_ON;
      end
   end

   // Latch the digit pattern and brightness once per slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dig_q  <= SEG_BLANK;
         r_bright <= 3'd0;
      end else if (w_slot_start) begin
         r_dig_q  <= w_led[w_idx];
         r_bright <= bright;
      end
   end

   // Free-running blink divider; bp toggles at each terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bc <= '0;
         r_bp <= 1'b0;
      end else if (!en) begin
         r_bc <= '0;
         r_bp <= 1'b0;
      end else if (r_bc == BW'(BLINK_TC)) begin
         r_bc <= '0;
         r_bp <= ~r_bp;
      end else begin
         r_bc <= r_bc + 1'b1;
      end
   end

   // Registered pin drivers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an_n        <= 8'hFF;
         r_seg_n       <= SEG_BLANK;
         r_frame_start <= 1'b0;
      end else if (!en) begin
         r_an_n        <= 8'hFF;
         r_seg_n       <= SEG_BLANK;
         r_frame_start <= 1'b0;
      end else begin
         r_an_n        <= (w_phase == PH_ON) ? w_an_on : 8'hFF;
         r_seg_n       <= w_blank_blink ? SEG_BLANK : w_dig_next;
         r_frame_start <= w_frame_start;
      end
   end

   assign seg_n       = r_seg_n;
   assign an_n        = r_an_n;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan with DWELL = 9, BLANK_CYC = 2, blink phase every
// 100 cycles. Output cycle k counts negedges after the first enabled posedge.
module tb_display_scan;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [6:0] led_in [8];
   logic [7:0] blink_mask;
   logic [2:0] bright;
   logic [6:0] seg_n;
   logic [7:0] an_n;
   logic       frame_start;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         bright;
      logic [7:0] mask;
      int         exp_on;
      int         n_cyc;
   } vec_t;

   vec_t vecs [6];

   display_scan #(
      .CLK_HZ    (1000),
      .DIGIT_HZ  (100),
      .BLANK_CYC (2),
      .BLINK_HZ  (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .led1        (led_in[0]),
      .led2        (led_in[1]),
      .led3        (led_in[2]),
      .led4        (led_in[3]),
      .led5        (led_in[4]),
      .led6        (led_in[5]),
      .led7        (led_in[6]),
      .led8        (led_in[7]),
      .blink_mask  (blink_mask),
      .bright      (bright),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_blank(input string tag);
      chk({tag, "_an_n"}, 32'(an_n), 32'h0FF);
      chk({tag, "_seg_n"}, 32'(seg_n), 32'h07F);
      chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
   endtask

   // Hold en low for one edge so the scan restarts at slot 0 on the next edge.
   task automatic restart();
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
   endtask

   // Check n_cyc output cycles of scanning from slot 0. Optionally change
   // led1 right after the check of cycle change_k.
   task automatic run_check(input int n_cyc, input int exp_on, input int change_k,
                            input logic [6:0] new_led1);
      logic [6:0] exp_dig;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      int s;
      int c;
      exp_dig = 7'h7F;
      for (int k = 0; k < n_cyc; k++) begin
         @(negedge clk);
         s = (k / 10) % 8;
         c = k % 10;
         if (c == 0) exp_dig = led_in[s];
         exp_an  = (c >= 2 && c < 2 + exp_on) ? ~(8'h01 << s) : 8'hFF;
         exp_seg = (blink_mask[s] && ((k / 100) % 2 == 1)) ? 7'h7F : exp_dig;
         chk("an_n", 32'(an_n), 32'(exp_an));
         chk("seg_n", 32'(seg_n), 32'(exp_seg));
         chk("frame_start", 32'(frame_start), 32'(k % 80 == 0));
         chk("one_anode", 32'($countones(~an_n) <= 1), 32'h1);
         if (k == change_k) led_in[0] = new_led1;
      end
   endtask

   initial begin
      vecs[0] = '{bright: 7, mask: 8'h00, exp_on: 8, n_cyc: 80};
      vecs[1] = '{bright: 0, mask: 8'h00, exp_on: 1, n_cyc: 80};
      vecs[2] = '{bright: 3, mask: 8'h00, exp_on: 4, n_cyc: 80};
      vecs[3] = '{bright: 5, mask: 8'h00, exp_on: 6, n_cyc: 80};
      vecs[4] = '{bright: 7, mask: 8'h03, exp_on: 8, n_cyc: 240};
      vecs[5] = '{bright: 1, mask: 8'h80, exp_on: 2, n_cyc: 240};

      led_in[0] = 7'h79; led_in[1] = 7'h24; led_in[2] = 7'h30; led_in[3] = 7'h19;
      led_in[4] = 7'h12; led_in[5] = 7'h02; led_in[6] = 7'h78; led_in[7] = 7'h40;
      blink_mask = 8'h00;
      bright     = 3'd7;
      en         = 1'b0;
      rst_n      = 1'b0;

      // Reset, then idle with en low.
      repeat (3) begin
         @(negedge clk);
         chk_blank("reset");
      end
      rst_n = 1'b1;
      repeat (50) begin
         @(negedge clk);
         chk_blank("idle");
      end

      // Brightness and blink vectors.
      for (int i = 0; i < 6; i++) begin
         bright     = 3'(vecs[i].bright);
         blink_mask = vecs[i].mask;
         restart();
         run_check(vecs[i].n_cyc, vecs[i].exp_on, -1, 7'h00);
      end

      // led1 changes mid-slot 0: old value to slot end, new value next frame.
      bright     = 3'd7;
      blink_mask = 8'h00;
      restart();
      run_check(90, 8, 5, 7'h12);
      led_in[0] = 7'h79;

      // Drop en at idx 5, cnt 6: blank from the next cycle, restart at slot 0.
      restart();
      run_check(56, 8, -1, 7'h00);
      en = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk_blank("en_drop");
      end
      en = 1'b1;
      run_check(80, 8, -1, 7'h00);

      // Pulse rst_n at idx 5, cnt 6: blank immediately, restart at slot 0.
      restart();
      run_check(56, 8, -1, 7'h00);
      #1 rst_n = 1'b0;
      #1 chk_blank("async_rst");
      @(negedge clk);
      chk_blank("rst_hold");
      rst_n = 1'b1;
      run_check(80, 8, -1, 7'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
